// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, parallel load, enable and wrap/saturate mode.
// Optional registered Gray-code output enabled by defining SYNC_UPDOWN_COUNTER_GRAY_EN.
module sync_updown_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc
`ifdef SYNC_UPDOWN_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] gray_out
`endif
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Top count value held in WIDTH bits, so the boundary test never overflows at MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic             tc_q;
  logic             tc_next;

  always_comb begin
    count_next = count_q;
    tc_next    = 1'b0;
    if (load) begin
      count_next = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q != MAX) begin
          count_next = count_q + WIDTH'(1);
        end else begin
          tc_next = 1'b1;
          if (!sat) count_next = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_next = count_q - WIDTH'(1);
        end else begin
          tc_next = 1'b1;
          if (!sat) count_next = MAX;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_next;
      tc_q    <= tc_next;
    end
  end

  assign out = count_q;
  assign tc  = tc_q;

`ifdef SYNC_UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Encoded from the next count so gray_out lines up with out in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= count_next ^ (count_next >> 1);
    end
  end

  assign gray_out = gray_q;
`endif

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed-vector bench for sync_updown_counter at WIDTH=4, MODULUS=10.
module tb_sync_updown_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_out;
    logic       exp_tc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] out;
  logic       tc;
`ifdef SYNC_UPDOWN_COUNTER_GRAY_EN
  logic [3:0] gray_out;
`endif

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sync_updown_counter #(
    .WIDTH  (4),
    .MODULUS(10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .tc      (tc)
`ifdef SYNC_UPDOWN_COUNTER_GRAY_EN
    ,
    .gray_out(gray_out)
`endif
  );

  task automatic add(input logic r, input logic e, input logic u, input logic s,
                     input logic l, input logic [3:0] lv, input logic [3:0] eo, input logic et);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.sat = s; v.load = l; v.load_val = lv;
    v.exp_out = eo; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  task automatic step(input string name, input vec_t v);
    logic [3:0] exp_gray;
    @(negedge clk);
    rst = v.rst; en = v.en; up = v.up; sat = v.sat; load = v.load; load_val = v.load_val;
    @(posedge clk);
    #1;
    compared++;
    if (out !== v.exp_out || tc !== v.exp_tc) begin
      mismatched++;
      $display("FAIL %s: out=%0d tc=%b, required out=%0d tc=%b", name, out, tc, v.exp_out, v.exp_tc);
    end
    exp_gray = v.exp_out ^ (v.exp_out >> 1);
`ifdef SYNC_UPDOWN_COUNTER_GRAY_EN
    compared++;
    if (gray_out !== exp_gray) begin
      mismatched++;
      $display("FAIL %s gray: gray_out=%b, required %b", name, gray_out, exp_gray);
    end
`endif
  endtask

  initial begin
    vec_t v;
    int tc_count;

    // reset
    add(0,1,1,0,1,4'd5, 0,0);
    add(0,1,1,0,0,4'd0, 0,0);
    // count up with wrap: 1..9,0,1,2
    for (int i = 1; i <= 12; i++)
      add(1,1,1,0,0,4'd0, 4'(i % 10), (i == 10));
    // load 3, then count down 2,1,0,9,8
    add(1,1,0,0,1,4'd3, 3,0);
    add(1,1,0,0,0,4'd0, 2,0);
    add(1,1,0,0,0,4'd0, 1,0);
    add(1,1,0,0,0,4'd0, 0,0);
    add(1,1,0,0,0,4'd0, 9,1);
    add(1,1,0,0,0,4'd0, 8,0);
    // saturate at top from 8
    add(1,0,1,1,0,4'd0, 8,0);
    add(1,1,1,1,0,4'd0, 9,0);
    add(1,1,1,1,0,4'd0, 9,1);
    add(1,1,1,1,0,4'd0, 9,1);
    add(1,1,1,1,0,4'd0, 9,1);
    // leaving enable drops tc, direction change steps down
    add(1,0,1,1,0,4'd0, 9,0);
    add(1,1,0,1,0,4'd0, 8,0);
    // load clamp with en high, then hold
    add(1,1,1,0,1,4'd14, 9,0);
    add(1,0,1,0,0,4'd0, 9,0);
    add(1,0,0,1,0,4'd0, 9,0);
    add(1,0,0,0,1,4'd10, 9,0);
    add(1,0,0,0,1,4'd9, 9,0);
    add(1,0,0,0,1,4'd15, 9,0);
    add(1,1,0,0,1,4'd0, 0,0);
    // saturate at bottom
    add(1,1,0,1,0,4'd0, 0,1);
    add(1,1,0,1,0,4'd0, 0,1);
    add(1,1,1,1,0,4'd0, 1,0);
    // reset beats load mid-count, then resume from 0
    add(1,1,1,0,1,4'd5, 5,0);
    add(1,1,1,0,0,4'd0, 6,0);
    add(0,1,1,0,1,4'd2, 0,0);
    add(1,1,1,0,0,4'd0, 1,0);
    add(1,1,1,0,0,4'd0, 2,0);
    // reset clears a pending tc
    add(1,1,0,0,1,4'd0, 0,0);
    add(1,1,0,1,0,4'd0, 0,1);
    add(0,1,0,1,0,4'd0, 0,0);

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Long wrap run: exactly two tc pulses across 20 up-steps from 0
    v.rst = 1; v.en = 1; v.up = 1; v.sat = 0; v.load = 0; v.load_val = 0;
    tc_count = 0;
    for (int i = 1; i <= 20; i++) begin
      v.exp_out = 4'(i % 10);
      v.exp_tc  = (i % 10 == 0);
      step($sformatf("wrap%0d", i), v);
      if (tc === 1'b1) tc_count++;
    end
    compared++;
    if (tc_count != 2) begin
      mismatched++;
      $display("FAIL wrap_tc_count: got %0d pulses, required 2", tc_count);
    end

    // Wrap down past 0 twice with a direction flip between
    v.up = 0;
    v.exp_out = 9; v.exp_tc = 1; step("down_wrap_a", v);
    v.up = 1;
    v.exp_out = 0; v.exp_tc = 1; step("up_wrap_b", v);
    v.up = 0;
    v.exp_out = 9; v.exp_tc = 1; step("down_wrap_c", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
